// File: rtl/fir_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fir_sched_pkg
// Purpose  : Shared FSM state type and channel-index width helper for the
//            FIR channel scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Round-robin grant over NUM_CH requests; the pointer names the
//            highest-priority channel and moves past the winner on accept.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int CH_W   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_accept,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_grant_idx,
    output logic              o_valid
);

    logic [CH_W-1:0] r_ptr;
    int              w_j;
    logic [CH_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_j         = 0;
        w_idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_j = int'(r_ptr) + i;
            if (w_j >= NUM_CH) begin
                w_j = w_j - NUM_CH;
            end
            w_idx = CH_W'(w_j);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

    assign o_valid = w_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_accept && w_found) begin
            r_ptr <= (o_grant_idx == CH_W'(NUM_CH - 1)) ? '0 : o_grant_idx + CH_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fir_channel_scheduler
// Purpose  : Time-shares one FIR engine between NUM_CH sample channels with
//            one job in flight; optional sticky overrun flags are enabled by
//            the FIR_SCHED_OVERRUN_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter  int NUM_CH         = 2,
    parameter  int DATA_W         = 16,
    parameter  int ENGINE_LATENCY = 5,
    localparam int CH_W           = ch_width(NUM_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH*DATA_W-1:0] sample_i,
    input  logic [NUM_CH-1:0]        sample_valid_i,
    output logic                     engine_tick_o,
    output logic [DATA_W-1:0]        engine_sample_o,
    output logic [CH_W-1:0]          engine_ch_o,
    input  logic [DATA_W-1:0]        engine_result_i,
    output logic [DATA_W-1:0]        result_o,
    output logic [CH_W-1:0]          result_ch_o,
    output logic                     result_valid_o,
    output logic                     busy_o,
    output logic [NUM_CH-1:0]        overrun_o
);

    localparam int c_CNT_W = (ENGINE_LATENCY > 2) ? $clog2(ENGINE_LATENCY - 1) : 1;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_hold [NUM_CH];
    logic [NUM_CH-1:0]   r_pending;
    logic [NUM_CH-1:0]   w_grant;
    logic [CH_W-1:0]     w_grant_idx;
    logic                w_grant_any;
    logic                w_grant_en;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_req       (r_pending),
        .i_accept    (r_state == IDLE),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_valid     (w_grant_any)
    );

    assign w_grant_en = (r_state == IDLE) && w_grant_any;

    // A strobe in the grant cycle re-arms pending: the grant takes the old sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_hold[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (sample_valid_i[k]) begin
                    r_hold[k]    <= sample_i[k*DATA_W +: DATA_W];
                    r_pending[k] <= 1'b1;
                end else if (w_grant_en && w_grant[k]) begin
                    r_pending[k] <= 1'b0;
                end
            end
        end
    end

`ifdef FIR_SCHED_OVERRUN_EN
    logic [NUM_CH-1:0] r_overrun;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overrun <= '0;
        end else begin
            r_overrun <= r_overrun | (sample_valid_i & r_pending & ~(w_grant & {NUM_CH{w_grant_en}}));
        end
    end

    assign overrun_o = r_overrun;
`else
    assign overrun_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            engine_tick_o   <= 1'b0;
            engine_sample_o <= '0;
            engine_ch_o     <= '0;
            result_o        <= '0;
            result_ch_o     <= '0;
            result_valid_o  <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            result_valid_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_en) begin
                        engine_sample_o <= r_hold[w_grant_idx];
                        engine_ch_o     <= w_grant_idx;
                        engine_tick_o   <= 1'b1;
                        busy_o          <= 1'b1;
                        r_state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    engine_tick_o <= 1'b0;
                    r_cnt         <= c_CNT_W'(ENGINE_LATENCY - 2);
                    r_state       <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    result_o       <= engine_result_i;
                    result_ch_o    <= engine_ch_o;
                    result_valid_o <= 1'b1;
                    busy_o         <= 1'b0;
                    r_state        <= IDLE;
                end
                default: begin
                    engine_tick_o <= 1'b0;
                    busy_o        <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fir_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_channel_scheduler
// Purpose  : Directed self-checking bench with a 5-cycle doubling engine stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_channel_scheduler;

    logic        clk;
    logic        rst;
    logic [31:0] sample;
    logic [1:0]  sample_valid;
    logic        engine_tick;
    logic [15:0] engine_sample;
    logic        engine_ch;
    logic [15:0] engine_result;
    logic [15:0] result;
    logic        result_ch;
    logic        result_valid;
    logic        busy;
    logic [1:0]  overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc;
    int seen;

    logic [1:0] c_ovr_exp;

    fir_channel_scheduler #(
        .NUM_CH         (2),
        .DATA_W         (16),
        .ENGINE_LATENCY (5)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .sample_i        (sample),
        .sample_valid_i  (sample_valid),
        .engine_tick_o   (engine_tick),
        .engine_sample_o (engine_sample),
        .engine_ch_o     (engine_ch),
        .engine_result_i (engine_result),
        .result_o        (result),
        .result_ch_o     (result_ch),
        .result_valid_o  (result_valid),
        .busy_o          (busy),
        .overrun_o       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine stub: result = 2*sample, valid 5 cycles after the tick cycle.
    logic [15:0] r_pipe [5];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= engine_tick ? (engine_sample << 1) : 16'h0000;
            for (int i = 1; i < 5; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end
    assign engine_result = r_pipe[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_result(input string tag, input logic [15:0] exp_data, input logic exp_ch);
        int n;
        n = 0;
        while (result_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_seen"}, result_valid, 1);
        chk({tag, "_data"}, result, exp_data);
        chk({tag, "_ch"}, result_ch, exp_ch);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
`ifdef FIR_SCHED_OVERRUN_EN
        c_ovr_exp = 2'b10;
`else
        c_ovr_exp = 2'b00;
`endif
        rst          = 1'b1;
        sample       = '0;
        sample_valid = '0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_tick", engine_tick, 0);
        chk("rst_esample", engine_sample, 0);
        chk("rst_ech", engine_ch, 0);
        chk("rst_result", result, 0);
        chk("rst_rvalid", result_valid, 0);
        chk("rst_overrun", overrun, 0);

        // Single sample on ch0: tick two cycles after the strobe, result 6 later
        sample[15:0] = 16'h0100;
        sample_valid = 2'b01;
        @(negedge clk);
        sample_valid = 2'b00;
        chk("single_idle", busy, 0);
        @(negedge clk);
        chk("single_tick", engine_tick, 1);
        chk("single_esample", engine_sample, 16'h0100);
        chk("single_ech", engine_ch, 0);
        chk("single_busy", busy, 1);
        @(negedge clk);
        chk("single_tick_pulse", engine_tick, 0);
        n_cyc = 1;
        while (result_valid !== 1'b1 && n_cyc < 20) begin
            @(negedge clk);
            n_cyc++;
        end
        chk("single_latency", n_cyc, 6);
        chk("single_data", result, 16'h0200);
        chk("single_ch", result_ch, 0);
        @(negedge clk);
        chk("single_rvalid_pulse", result_valid, 0);
        chk("single_done", busy, 0);

        // Round-robin from a fresh pointer, then repeated after ch1 was last
        do_reset();
        sample       = {16'h0020, 16'h0010};
        sample_valid = 2'b11;
        @(negedge clk);
        sample_valid = 2'b00;
        wait_result("rr1_ch0", 16'h0020, 1'b0);
        wait_result("rr1_ch1", 16'h0040, 1'b1);
        sample_valid = 2'b11;
        @(negedge clk);
        sample_valid = 2'b00;
        wait_result("rr2_ch0", 16'h0020, 1'b0);
        wait_result("rr2_ch1", 16'h0040, 1'b1);
        repeat (3) @(negedge clk);
        chk("rr_no_extra", busy, 0);

        // Overrun: ch1 written twice while ch0 job runs
        sample[15:0] = 16'h0003;
        sample_valid = 2'b01;
        @(negedge clk);
        sample_valid = 2'b00;
        repeat (3) @(negedge clk);
        sample[31:16] = 16'h0005;
        sample_valid  = 2'b10;
        @(negedge clk);
        sample[31:16] = 16'h0007;
        sample_valid  = 2'b10;
        @(negedge clk);
        sample_valid = 2'b00;
        chk("ovr_flag", overrun, c_ovr_exp);
        wait_result("ovr_ch0", 16'h0006, 1'b0);
        wait_result("ovr_ch1", 16'h000E, 1'b1);
        chk("ovr_sticky", overrun, c_ovr_exp);
        do_reset();
        chk("ovr_cleared", overrun, 0);

        // Same-cycle grant: new ch0 sample lands on the grant edge
        sample[15:0] = 16'h0011;
        sample_valid = 2'b01;
        @(negedge clk);
        sample[15:0] = 16'h0022;
        @(negedge clk);
        sample_valid = 2'b00;
        chk("same_tick", engine_tick, 1);
        chk("same_esample", engine_sample, 16'h0011);
        wait_result("same_job1", 16'h0022, 1'b0);
        wait_result("same_job2", 16'h0044, 1'b0);
        chk("same_no_overrun", overrun, 0);

        // Reset during WAIT abandons the job
        sample[31:16] = 16'h0009;
        sample_valid  = 2'b10;
        @(negedge clk);
        sample_valid = 2'b00;
        @(negedge clk);
        chk("rw_tick", engine_tick, 1);
        repeat (2) @(negedge clk);
        chk("rw_busy_wait", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (result_valid === 1'b1) seen = 1;
        end
        chk("rw_no_result", seen, 0);
        chk("rw_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fir_channel_scheduler.md
FIR_CHANNEL_SCHEDULER -- requirements
Module: fir_channel_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of requesting channels sharing one FIR engine, at least 2.
REQ-002 SHALL have parameter DATA_W, default 16: sample and result width, equal to the engine num_of_bits_io.
REQ-003 SHALL have parameter ENGINE_LATENCY, default 5: cycles from the engine tick cycle to the first cycle the engine result is valid (stages+2).
REQ-004 SHALL derive CH_W = max(1, $clog2(NUM_CH)).
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port sample_i, input, NUM_CH*DATA_W bits: packed signed samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port sample_valid_i, input, NUM_CH bits: per-channel sample strobe, one cycle per sample.
REQ-009 SHALL have port engine_tick_o, output, 1 bit: start pulse to the FIR engine tick_i.
REQ-010 SHALL have port engine_sample_o, output, DATA_W bits: registered sample to the engine signal_i.
REQ-011 SHALL have port engine_ch_o, output, CH_W bits: granted channel, for external coefficient or state bank select.
REQ-012 SHALL have port engine_result_i, input, DATA_W bits: engine signal_o.
REQ-013 SHALL have port result_o, output, DATA_W bits: captured filter result.
REQ-014 SHALL have port result_ch_o, output, CH_W bits: channel of result_o.
REQ-015 SHALL have port result_valid_o, output, 1 bit: one-cycle strobe qualifying result_o and result_ch_o.
REQ-016 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-017 SHALL have port overrun_o, output, NUM_CH bits: sticky per-channel overrun flags.

Function
REQ-018 SHALL hold, per channel, a DATA_W hold register and a pending bit; sample_valid_i[k] SHALL load the hold register and set pending[k].
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT and CAPTURE; any other encoding SHALL go to IDLE.
REQ-020 In IDLE with any pending bit set, the block SHALL grant one channel round-robin, starting after the last granted channel and favouring channel 0 after reset.
REQ-021 On grant, the block SHALL load engine_sample_o and engine_ch_o, clear pending for that channel, and move to ISSUE.
REQ-022 In ISSUE, engine_tick_o SHALL be 1 for exactly that cycle; the wait counter SHALL be loaded; the FSM SHALL move to WAIT.
REQ-023 WAIT SHALL last ENGINE_LATENCY-1 cycles, so that CAPTURE occurs exactly ENGINE_LATENCY cycles after the ISSUE cycle.
REQ-024 In CAPTURE, the block SHALL register engine_result_i into result_o and engine_ch_o into result_ch_o.
REQ-025 result_valid_o SHALL be high in the cycle after CAPTURE only; the FSM SHALL return to IDLE.
REQ-026 engine_sample_o and engine_ch_o SHALL stay stable from grant until the FSM returns to IDLE.
REQ-027 A sample_valid_i[k] arriving in the same cycle channel k is granted SHALL be stored with pending[k] left set; this SHALL NOT count as an overrun, and the grant SHALL use the previously held sample.
REQ-028 A sample_valid_i[k] arriving while pending[k] is set and channel k is not being granted SHALL overwrite the held sample (newest wins) and set overrun_o[k].
REQ-029 Samples arriving during ISSUE, WAIT or CAPTURE SHALL only update hold and pending state; at most one engine job SHALL be in flight.

Reset
REQ-030 While rst_i is high at a clock edge, the block SHALL set FSM to IDLE and clear pending, hold registers, counter, round-robin pointer, engine_tick_o, engine_sample_o, engine_ch_o, result_o, result_ch_o, result_valid_o, busy_o and overrun_o to 0.
REQ-031 Reset mid-job SHALL abandon the job with no result_valid_o pulse; the engine is reset by the same rst_i.

Configuration
REQ-032 With macro FIR_SCHED_OVERRUN_EN defined, overrun_o SHALL behave per REQ-028; without it, overrun_o SHALL be tied to 0 and the flag registers omitted, while overwrite behaviour is unchanged.

Structure
REQ-033 Package fir_sched_pkg SHALL hold the state_t enum (IDLE, ISSUE, WAIT, CAPTURE) and the CH_W derivation function.
REQ-034 A sub-module rr_arbiter SHALL implement the round-robin pointer and grant: NUM_CH requests, one-hot grant plus index, pointer advancing on accept.

Verification (NUM_CH=2, DATA_W=16, ENGINE_LATENCY=5; engine stub returns 2*sample after 5 cycles)
REQ-035 Reset check: rst_i high for 2 cycles -> all outputs 0 and busy_o=0 in the next cycle.
REQ-036 Single sample: ch0 sample 0x0100 with valid at cycle 10 -> engine_tick_o=1 at cycle 12 -> result_valid_o=1 at cycle 18 with result_o=0x0200 and result_ch_o=0.
REQ-037 Round-robin: both channels valid at once with samples 0x0010 and 0x0020 -> results for ch0 (0x0020) then ch1 (0x0040); a repeat of the stimulus after ch1 was last granted -> ch0 served first again; no lost samples.
REQ-038 Overrun: ch1 valid with 0x0005, then 0x0007, both during a ch0 job -> overrun_o[1]=1 and ch1 result=0x000E.
REQ-039 Same-cycle grant: ch0 valid at its grant cycle -> no overrun, and a second ch0 job follows with the new sample.
REQ-040 Reset in WAIT -> no result_valid_o pulse, busy_o=0; without FIR_SCHED_OVERRUN_EN the REQ-038 stimulus leaves overrun_o=0.
